// File: rtl/sram_rw_port_ctrl_if.sv
// Request/response bus between a bus master and sram_rw_port_ctrl.
// Signal names keep the controller's port naming so both sides read alike.
interface sram_rw_port_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [NUM_WMASKS-1:0] req_be_i;
    logic [31:0]           req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_be_i, req_addr_i, req_wdata_i,
        output rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_be_i, req_addr_i, req_wdata_i,
        input  rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/sram_rw_port_ctrl.sv
// Front-end for the read/write port of the 32x1024 OpenRAM macro.
// Define SRAM_RW_PORT_CTRL_INIT_EN to zero the whole macro after reset.
module sram_rw_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_WMASKS = 4,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    sram_rw_port_ctrl_if.slave    bus,
    output logic                  init_done_o,
    output logic                  sram_csb0_o,
    output logic                  sram_web0_o,
    output logic [NUM_WMASKS-1:0] sram_wmask0_o,
    output logic [ADDR_WIDTH-1:0] sram_addr0_o,
    output logic [DATA_WIDTH-1:0] sram_din0_o,
    input  logic [DATA_WIDTH-1:0] sram_dout0_i
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 2);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t state_q, state_d;

    logic                  fire;
    logic                  in_range;
    logic                  pop;
    logic                  push;
    logic                  full;
    logic [CW-1:0]         occ;
    logic [ADDR_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] push_data;
    logic [1:0]            unused_addr;

    logic                  infl_q;
    logic                  infl_rd_q;
    logic                  infl_err_q;

    logic [DATA_WIDTH-1:0] data_q [RSP_DEPTH];
    logic                  err_q  [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;

    assign unused_addr = bus.req_addr_i[1:0];
    assign word        = bus.req_addr_i[ADDR_WIDTH+1:2];
    assign in_range    = (bus.req_addr_i[31:ADDR_WIDTH+2] == '0);

    assign init_done_o = (state_q == S_RUN);
    assign pop         = bus.rsp_valid_o & bus.rsp_ready_i;
    // Slots already committed: queued, in flight, minus the one leaving now.
    assign occ         = count_q + CW'(infl_q) - CW'(pop);
    assign bus.req_ready_o = init_done_o & (occ < CW'(RSP_DEPTH));
    assign fire        = bus.req_valid_i & bus.req_ready_o;

`ifdef SRAM_RW_PORT_CTRL_INIT_EN
    logic [ADDR_WIDTH-1:0] init_cnt_q;

    // Sweep address counter used while zeroing the macro.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_cnt_q <= '0;
        end else if (state_q == S_INIT) begin
            init_cnt_q <= init_cnt_q + 1'b1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and macro pin drive.
    always_comb begin
        state_d       = state_q;
        sram_csb0_o   = 1'b1;
        sram_web0_o   = 1'b1;
        sram_wmask0_o = '0;
        sram_addr0_o  = '0;
        sram_din0_o   = '0;
        unique case (state_q)
            S_INIT: begin
`ifdef SRAM_RW_PORT_CTRL_INIT_EN
                if (rst_ni) begin
                    sram_csb0_o   = 1'b0;
                    sram_web0_o   = 1'b0;
                    sram_wmask0_o = '1;
                    sram_addr0_o  = init_cnt_q;
                end
                if (&init_cnt_q) begin
                    state_d = S_RUN;
                end
`else
                state_d = S_RUN;
`endif
            end
            S_RUN: begin
                sram_addr0_o = word;
                sram_din0_o  = bus.req_wdata_i;
                if (fire && in_range) begin
                    sram_csb0_o   = 1'b0;
                    sram_web0_o   = ~bus.req_we_i;
                    sram_wmask0_o = bus.req_be_i;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // One-deep in-flight record of the request the macro just sampled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            infl_q     <= 1'b0;
            infl_rd_q  <= 1'b0;
            infl_err_q <= 1'b0;
        end else begin
            infl_q     <= fire;
            infl_rd_q  <= fire & ~bus.req_we_i;
            infl_err_q <= fire & ~in_range;
        end
    end

    assign push      = infl_q;
    assign push_data = (infl_rd_q && !infl_err_q) ? sram_dout0_i : '0;
    assign full      = (count_q == CW'(RSP_DEPTH));

    // Response FIFO storage and pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                data_q[i] <= '0;
                err_q[i]  <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= push_data;
                err_q[wr_ptr_q]  <= infl_err_q;
                wr_ptr_q <= (wr_ptr_q == PW'(RSP_DEPTH - 1)) ?
                            '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(RSP_DEPTH - 1)) ?
                            '0 : rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign bus.rsp_valid_o = (count_q != '0);
    assign bus.rsp_rdata_o = bus.rsp_valid_o ? data_q[rd_ptr_q] : '0;
    assign bus.rsp_err_o   = bus.rsp_valid_o ? err_q[rd_ptr_q] : 1'b0;

    a_no_overflow : assert property (
        @(posedge clk_i) disable iff (!rst_ni) push |-> (!full || pop)
    );

    a_no_underflow : assert property (
        @(posedge clk_i) disable iff (!rst_ni) pop |-> (count_q != '0)
    );

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Randomized scoreboard bench for sram_rw_port_ctrl with a macro model.
// Expected responses come from a word-level shadow memory.
module tb_sram_rw_port_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef SRAM_RW_PORT_CTRL_INIT_EN
    localparam int EXP_INIT = 1024;
`else
    localparam int EXP_INIT = 1;
`endif

    sram_rw_port_ctrl_if bus ();

    logic        init_done;
    logic        csb;
    logic        web;
    logic [3:0]  wmask;
    logic [9:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;

    sram_rw_port_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus),
        .init_done_o   (init_done),
        .sram_csb0_o   (csb),
        .sram_web0_o   (web),
        .sram_wmask0_o (wmask),
        .sram_addr0_o  (addr),
        .sram_din0_o   (din),
        .sram_dout0_i  (dout)
    );

    // Macro model: pins sampled at posedge, array access at the negedge,
    // output garbage again shortly after the following posedge.
    logic [31:0] sram [0:1023];
    logic        l_csb = 1'b1;
    logic        l_web = 1'b1;
    logic [3:0]  l_m = 4'h0;
    logic [9:0]  l_a = 10'h0;
    logic [31:0] l_d = 32'h0;

    always @(posedge clk) begin
        l_csb <= csb;
        l_web <= web;
        l_m   <= wmask;
        l_a   <= addr;
        l_d   <= din;
    end

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = $urandom;
        dout = $urandom;
        forever begin
            @(negedge clk);
            if (!l_csb && !l_web) begin
                for (int b = 0; b < 4; b++)
                    if (l_m[b]) sram[l_a][8*b +: 8] = l_d[8*b +: 8];
            end else if (!l_csb) begin
                dout = sram[l_a];
            end
            @(posedge clk);
            #2 dout = $urandom;
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        bit          chk;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [0:1023];
    bit          known [0:1023];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rnd_rdy = 1'b0;

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic ref_zero();
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = 32'h0;
            known[i]   = 1'b1;
        end
    endtask

    // Producer: on each accepted request, compute the expected response.
    initial begin
        logic [9:0] w;
        bit         inr;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.req_valid_i && bus.req_ready_o) begin
                w   = bus.req_addr_i[11:2];
                inr = (bus.req_addr_i[31:12] == 20'h0);
                e.err   = !inr;
                e.rdata = 32'h0;
                e.chk   = 1'b1;
                chk(csb == !inr, "csb on fire", {31'h0, csb}, {31'h0, !inr});
                if (inr) begin
                    chk(addr == w && web == !bus.req_we_i &&
                        wmask == bus.req_be_i && din == bus.req_wdata_i,
                        "macro pins", {12'h0, addr, web, wmask, 5'h0},
                        {12'h0, w, !bus.req_we_i, bus.req_be_i, 5'h0});
                    if (bus.req_we_i) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.req_be_i[b])
                                ref_mem[w][8*b +: 8] = bus.req_wdata_i[8*b +: 8];
                        if (bus.req_be_i == 4'hF) known[w] = 1'b1;
                    end else begin
                        e.rdata = ref_mem[w];
                        e.chk   = known[w];
                    end
                end
                q.push_back(e);
            end else if (rst_n && init_done) begin
                chk(csb && web && wmask == 4'h0, "idle pins",
                    {26'h0, csb, web, wmask}, {26'h0, 2'b11, 4'h0});
            end
        end
    end

    // Monitor: compare each consumed response with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected rsp", bus.rsp_rdata_o, 32'h0);
                end else begin
                    e = q.pop_front();
                    chk(bus.rsp_err_o == e.err, "rsp err",
                        {31'h0, bus.rsp_err_o}, {31'h0, e.err});
                    if (e.chk)
                        chk(bus.rsp_rdata_o == e.rdata, "rsp rdata",
                            bus.rsp_rdata_o, e.rdata);
                end
            end
        end
    end

    task automatic rand_ready();
        if (rnd_rdy) bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 rand_ready();
        end
    endtask

    task automatic send(input bit we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d);
        int t = 0;
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_be_i    = be;
        bus.req_addr_i  = a;
        bus.req_wdata_i = d;
        forever begin
            @(negedge clk);
            if (bus.req_ready_o) break;
            t++;
            if (t > 200) begin
                chk(1'b0, "req timeout", t, 200);
                break;
            end
            @(posedge clk);
            #1 rand_ready();
        end
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        rand_ready();
    endtask

    task automatic release_and_wait();
        int cyc = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        forever begin
            @(posedge clk);
            #1 cyc++;
            if (init_done || cyc > 3000) break;
        end
        chk(cyc == EXP_INIT, "init cycles", cyc, EXP_INIT);
`ifdef SRAM_RW_PORT_CTRL_INIT_EN
        ref_zero();
`endif
    endtask

    initial begin
        logic [31:0] rd_addrs [4];
        logic [31:0] a;
        logic [19:0] hi;
        int          acc;

        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = 32'h0;
            known[i]   = 1'b0;
        end
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_be_i    = 4'h0;
        bus.req_addr_i  = 32'h0;
        bus.req_wdata_i = 32'h0;
        bus.rsp_ready_i = 1'b1;

        #2;
        chk(!bus.req_ready_o && !bus.rsp_valid_o && !bus.rsp_err_o &&
            !init_done, "reset ctl",
            {28'h0, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, init_done},
            32'h0);
        chk(bus.rsp_rdata_o == 32'h0, "reset rdata", bus.rsp_rdata_o, 32'h0);
        chk(csb && web && wmask == 4'h0, "reset pins",
            {26'h0, csb, web, wmask}, {26'h0, 2'b11, 4'h0});
        chk(addr == 10'h0 && din == 32'h0, "reset addr/din",
            din ^ {22'h0, addr}, 32'h0);

        release_and_wait();

`ifdef SRAM_RW_PORT_CTRL_INIT_EN
        send(1'b0, 4'h0, 32'h0000_0FFC, 32'h0);
        @(negedge clk);
        chk(bus.rsp_valid_o && bus.rsp_rdata_o == 32'h0, "init zero",
            bus.rsp_rdata_o, 32'h0);
        @(posedge clk);
        #1;
`endif

        send(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        send(1'b0, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        chk(bus.rsp_valid_o && bus.rsp_rdata_o == 32'h0, "raw rsp0",
            bus.rsp_rdata_o, 32'h0);
        @(negedge clk);
        chk(bus.rsp_valid_o && bus.rsp_rdata_o == 32'hDEAD_BEEF, "raw rsp1",
            bus.rsp_rdata_o, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;

        send(1'b1, 4'hF, 32'h20, 32'hAAAA_AAAA);
        send(1'b1, 4'b0101, 32'h20, 32'h1122_3344);
        send(1'b0, 4'h0, 32'h20, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk(bus.rsp_valid_o && bus.rsp_rdata_o == 32'hAA22_AA44, "byte mask",
            bus.rsp_rdata_o, 32'hAA22_AA44);
        @(posedge clk);
        #1;

        send(1'b1, 4'hF, 32'h30, 32'h1234_5678);
        send(1'b0, 4'h0, 32'h1000, 32'h0);
        send(1'b0, 4'h0, 32'h30, 32'h0);
        idle(4);

        rd_addrs[0] = 32'h10;
        rd_addrs[1] = 32'h20;
        rd_addrs[2] = 32'h30;
        rd_addrs[3] = 32'h10;
        bus.rsp_ready_i = 1'b0;
        acc = 0;
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b0;
        bus.req_be_i    = 4'h0;
        bus.req_addr_i  = rd_addrs[0];
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.req_ready_o) acc++;
            @(posedge clk);
            #1;
            if (acc < 4) bus.req_addr_i = rd_addrs[acc];
        end
        chk(acc == 2, "stall accepted", acc, 2);
        chk(!bus.req_ready_o, "stall ready", {31'h0, bus.req_ready_o}, 32'h0);
        bus.rsp_ready_i = 1'b1;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            @(negedge clk);
            if (bus.req_ready_o) acc++;
            @(posedge clk);
            #1;
            if (acc < 4) bus.req_addr_i = rd_addrs[acc];
            else bus.req_valid_i = 1'b0;
        end
        bus.req_valid_i = 1'b0;
        chk(acc == 4, "resume accepted", acc, 4);
        idle(4);

        bus.rsp_ready_i = 1'b0;
        send(1'b0, 4'h0, 32'h20, 32'h0);
        send(1'b0, 4'h0, 32'h30, 32'h0);
        idle(2);
        chk(bus.rsp_valid_o, "queued before rst",
            {31'h0, bus.rsp_valid_o}, 32'h1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk(!bus.rsp_valid_o, "rst rsp_valid", {31'h0, bus.rsp_valid_o}, 32'h0);
        chk(csb, "rst csb", {31'h0, csb}, 32'h1);
        chk(!bus.req_ready_o, "rst ready", {31'h0, bus.req_ready_o}, 32'h0);
        q.delete();
        bus.rsp_ready_i = 1'b1;
        release_and_wait();
        send(1'b0, 4'h0, 32'h10, 32'h0);
        idle(3);

        for (int i = 0; i < 16; i++)
            send(1'b1, 4'hF, 32'h100 + 32'(i * 4), $urandom);
        idle(3);

        rnd_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                hi = 20'($urandom_range(1, 20'hFFFFF));
                a  = {hi, 12'($urandom)};
            end else begin
                a = 32'h100 + 32'($urandom_range(0, 15) * 4);
            end
            send(1'($urandom), 4'($urandom), a, $urandom);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end

        rnd_rdy = 1'b0;
        bus.rsp_ready_i = 1'b1;
        for (int c = 0; c < 50 && q.size() != 0; c++) idle(1);
        chk(q.size() == 0, "drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
